// File: rtl/id_ex_queue_pkg.sv
// Shared configuration for the decode-to-execute queue: default widths, the bubble
// opcode and the reg1/reg2/imm/rd layout of the packed payload.
package id_ex_queue_pkg;

    localparam int CFG_DEPTH  = 2;
    localparam int CFG_ADDR_W = 32;
    localparam int CFG_OP_W   = 6;
    localparam int REG_W      = 32;
    localparam int RD_W       = 5;
    localparam int CFG_DATA_W = 3 * REG_W + RD_W;

    localparam logic [CFG_OP_W-1:0] NOP_OPCODE = '0;

    localparam logic            TRUE      = 1'b1;
    localparam logic            FALSE     = 1'b0;
    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    localparam int RD_LSB   = 0;
    localparam int IMM_LSB  = RD_LSB + RD_W;
    localparam int REG2_LSB = IMM_LSB + REG_W;
    localparam int REG1_LSB = REG2_LSB + REG_W;

    typedef struct packed {
        logic [REG_W-1:0] reg1;
        logic [REG_W-1:0] reg2;
        logic [REG_W-1:0] imm;
        logic [RD_W-1:0]  rd;
    } payload_t;

    function automatic logic [CFG_DATA_W-1:0] pack_payload(
        input logic [REG_W-1:0] reg1,
        input logic [REG_W-1:0] reg2,
        input logic [REG_W-1:0] imm,
        input logic [RD_W-1:0]  rd
    );
        payload_t p;
        p.reg1 = reg1;
        p.reg2 = reg2;
        p.imm  = imm;
        p.rd   = rd;
        return p;
    endfunction

    function automatic payload_t unpack_payload(input logic [CFG_DATA_W-1:0] data);
        return payload_t'(data);
    endfunction

endpackage

// File: rtl/id_ex_queue_if.sv
// Decode/execute handshake bundle; master is the pipeline around the queue,
// slave is the queue itself.
interface id_ex_queue_if
    import id_ex_queue_pkg::*;
#(
    parameter int DEPTH  = CFG_DEPTH,
    parameter int ADDR_W = CFG_ADDR_W,
    parameter int DATA_W = CFG_DATA_W,
    parameter int OP_W   = CFG_OP_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    logic              rdy;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_bubble;
    logic [ADDR_W-1:0] in_pc;
    logic [DATA_W-1:0] in_data;
    logic [OP_W-1:0]   in_op;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_data;
    logic [OP_W-1:0]   out_op;
    logic [CNT_W-1:0]  count;

    modport master (
        output rdy, flush, in_valid, in_bubble, in_pc, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_pc, out_data, out_op, count
    );

    modport slave (
        input  rdy, flush, in_valid, in_bubble, in_pc, in_data, in_op, out_ready,
        output in_ready, out_valid, out_pc, out_data, out_op, count
    );

endinterface

// File: rtl/id_ex_queue_queue_ctrl.sv
// Pointer/occupancy bookkeeping for the queue: push/pop/flush arbitration and the
// in_ready/out_valid flags, which depend on registered count only.
module id_ex_queue_queue_ctrl
    import id_ex_queue_pkg::*;
#(
    parameter int DEPTH = CFG_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic pop;

    assign in_ready  = (count != FULL) ? TRUE : FALSE;
    assign out_valid = (count != '0) ? TRUE : FALSE;
    assign push      = rdy & in_valid & in_ready & ~flush;
    assign pop       = rdy & out_valid & out_ready & ~flush;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/id_ex_queue.sv
// Elastic DEPTH-entry queue between decode and execute with flush, bubble injection
// and a global freeze; storage and the head output mux live here.
module id_ex_queue
    import id_ex_queue_pkg::*;
#(
    parameter int              DEPTH  = CFG_DEPTH,
    parameter int              ADDR_W = CFG_ADDR_W,
    parameter int              DATA_W = CFG_DATA_W,
    parameter int              OP_W   = CFG_OP_W,
    parameter logic [OP_W-1:0] NOP_OP = NOP_OPCODE
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [OP_W-1:0]   op_mem   [DEPTH];

    id_ex_queue_queue_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .rdy       (bus.rdy),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .push      (push),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (bus.count)
    );

    // NOTE: storage is reset explicitly so a freshly reset queue holds known NOP entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
                op_mem[i]   <= NOP_OP;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= bus.in_pc;
            data_mem[wr_ptr] <= bus.in_data;
            op_mem[wr_ptr]   <= bus.in_bubble ? NOP_OP : bus.in_op;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        bus.out_pc   = '0;
        bus.out_data = '0;
        bus.out_op   = NOP_OP;
        if (bus.out_valid) begin
            bus.out_pc   = pc_mem[rd_ptr];
            bus.out_data = data_mem[rd_ptr];
            bus.out_op   = op_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_id_ex_queue.sv
// Directed bench for id_ex_queue (DEPTH=2): reset, fill/drain, streaming,
// flush, bubble, freeze and asynchronous reset mid-run.
module tb_id_ex_queue;
    import id_ex_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    id_ex_queue_if bus ();

    id_ex_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] pc, input logic [5:0] op,
                         input logic bubble, input logic [CFG_DATA_W-1:0] data);
        bus.in_valid  = valid;
        bus.in_pc     = pc;
        bus.in_op     = op;
        bus.in_bubble = bubble;
        bus.in_data   = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CFG_DATA_W-1:0] d1;
        logic [CFG_DATA_W-1:0] d2;
        d1 = pack_payload(32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 5'd7);
        d2 = pack_payload(32'hAAAA_0001, 32'hBBBB_0002, ZERO_WORD, 5'd31);

        bus.rdy = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 6'h0, 1'b0, '0);

        // Reset state
        #1;
        check("rst_count", 128'(bus.count), 128'(0));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_op", 128'(bus.out_op), 128'(NOP_OPCODE));
        check("rst_out_pc", 128'(bus.out_pc), 128'(0));
        check("rst_out_data", 128'(bus.out_data), 128'(0));
        tick();
        tick();
        rst = 1'b1;
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));

        // Fill to full, third push refused, then drain
        drive(1'b1, 32'h100, 6'h05, 1'b0, d1);
        tick();
        check("fill1_count", 128'(bus.count), 128'(1));
        check("fill1_out_pc", 128'(bus.out_pc), 128'(32'h100));
        check("fill1_out_op", 128'(bus.out_op), 128'(6'h05));
        check("fill1_out_data", 128'(bus.out_data), 128'(d1));
        drive(1'b1, 32'h104, 6'h06, 1'b0, d2);
        tick();
        check("fill2_count", 128'(bus.count), 128'(2));
        check("fill2_in_ready", 128'(bus.in_ready), 128'(0));
        check("fill2_out_pc", 128'(bus.out_pc), 128'(32'h100));
        drive(1'b1, 32'h108, 6'h07, 1'b0, d1);
        tick();
        check("full_no_push_count", 128'(bus.count), 128'(2));
        drive(1'b0, 32'h0, 6'h0, 1'b0, '0);
        bus.out_ready = 1'b1;
        #1;
        check("drain_head0", 128'(bus.out_pc), 128'(32'h100));
        tick();
        check("drain_head1_pc", 128'(bus.out_pc), 128'(32'h104));
        check("drain_head1_op", 128'(bus.out_op), 128'(6'h06));
        check("drain_head1_data", 128'(bus.out_data), 128'(d2));
        check("drain_count1", 128'(bus.count), 128'(1));
        tick();
        check("drain_empty_valid", 128'(bus.out_valid), 128'(0));
        check("drain_empty_op", 128'(bus.out_op), 128'(NOP_OPCODE));
        check("drain_empty_pc", 128'(bus.out_pc), 128'(0));
        check("drain_empty_count", 128'(bus.count), 128'(0));

        // Streaming with simultaneous push/pop, pointers wrap repeatedly
        drive(1'b1, 32'h0, 6'h0, 1'b0, '0);
        tick();
        check("stream_first_pc", 128'(bus.out_pc), 128'(0));
        check("stream_first_count", 128'(bus.count), 128'(1));
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 32'(4 * i), 6'(i), 1'b0, CFG_DATA_W'(i * 3));
            tick();
            check($sformatf("stream_pc_%0d", i), 128'(bus.out_pc), 128'(4 * i));
            check($sformatf("stream_op_%0d", i), 128'(bus.out_op), 128'(i));
            check($sformatf("stream_data_%0d", i), 128'(bus.out_data), 128'(i * 3));
            check($sformatf("stream_count_%0d", i), 128'(bus.count), 128'(1));
        end
        drive(1'b0, 32'h0, 6'h0, 1'b0, '0);
        tick();
        check("stream_end_count", 128'(bus.count), 128'(0));

        // Flush drops queued entries and the incoming instruction
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h180, 6'h01, 1'b0, d1);
        tick();
        drive(1'b1, 32'h184, 6'h02, 1'b0, d2);
        tick();
        check("flush_pre_count", 128'(bus.count), 128'(2));
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h200, 6'h03, 1'b0, d1);
        tick();
        check("flush_count", 128'(bus.count), 128'(0));
        check("flush_out_valid", 128'(bus.out_valid), 128'(0));
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h300, 6'h04, 1'b0, d2);
        #1;
        check("post_flush_no_bypass", 128'(bus.out_valid), 128'(0));
        tick();
        check("post_flush_pc", 128'(bus.out_pc), 128'(32'h300));
        check("post_flush_count", 128'(bus.count), 128'(1));
        drive(1'b0, 32'h0, 6'h0, 1'b0, '0);
        bus.out_ready = 1'b1;
        tick();
        check("post_flush_drained", 128'(bus.count), 128'(0));

        // Bubble keeps PC/data but forces the opcode
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h40, 6'h13, 1'b1, d1);
        tick();
        check("bubble_valid", 128'(bus.out_valid), 128'(1));
        check("bubble_op", 128'(bus.out_op), 128'(NOP_OPCODE));
        check("bubble_pc", 128'(bus.out_pc), 128'(32'h40));
        check("bubble_data", 128'(bus.out_data), 128'(d1));
        drive(1'b1, 32'h44, 6'h13, 1'b0, d2);
        tick();
        check("bubble_next_count", 128'(bus.count), 128'(2));

        // Freeze: everything held, flush ignored until rdy returns
        bus.rdy = 1'b0;
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h500, 6'h09, 1'b0, d1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("freeze_count_%0d", i), 128'(bus.count), 128'(2));
            check($sformatf("freeze_pc_%0d", i), 128'(bus.out_pc), 128'(32'h40));
            check($sformatf("freeze_valid_%0d", i), 128'(bus.out_valid), 128'(1));
            check($sformatf("freeze_in_ready_%0d", i), 128'(bus.in_ready), 128'(0));
        end
        bus.rdy = 1'b1;
        tick();
        check("unfreeze_flush_count", 128'(bus.count), 128'(0));
        check("unfreeze_flush_valid", 128'(bus.out_valid), 128'(0));
        bus.flush = 1'b0;
        bus.rdy = 1'b0;
        drive(1'b1, 32'h600, 6'h0A, 1'b0, d2);
        tick();
        check("freeze_blocks_push", 128'(bus.count), 128'(0));
        check("freeze_in_ready_empty", 128'(bus.in_ready), 128'(1));
        bus.rdy = 1'b1;

        // Asynchronous reset with the queue full
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h700, 6'h0B, 1'b0, d1);
        tick();
        drive(1'b1, 32'h704, 6'h0C, 1'b0, d2);
        tick();
        check("mid_rst_pre_count", 128'(bus.count), 128'(2));
        rst = 1'b0;
        #1;
        check("mid_rst_count", 128'(bus.count), 128'(0));
        check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("mid_rst_out_op", 128'(bus.out_op), 128'(NOP_OPCODE));
        check("mid_rst_out_pc", 128'(bus.out_pc), 128'(0));
        check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
        drive(1'b0, 32'h0, 6'h0, 1'b0, '0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_count", 128'(bus.count), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/id_ex_queue.md
Name: id_ex_queue

Overview:
- Parametrised successor to the ID→EX pipeline register: a DEPTH-entry elastic queue between decode and execute with valid/ready handshake on both sides.
- Payload is generic (DATA_W bits packing reg1/reg2/imm/rd) plus PC and opcode.
- Adds a mispredict flush, bubble injection and a global rdy freeze.
- Lets decode keep issuing while execute is stalled on multi-cycle ops.

Parameters:
- DEPTH, 2, number of entries; power of two, ≥2
- ADDR_W, 32, PC width
- DATA_W, 101, packed payload width (reg1 32 + reg2 32 + imm 32 + rd 5)
- OP_W, 6, opcode width
- NOP_OP, 0, opcode value used for bubbles and empty output

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; 0 freezes all state
- flush  in  1  branch/jump taken: discard all entries
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  queue can accept (count < DEPTH)
- in_bubble  in  1  push as bubble: op forced to NOP_OP, other fields kept
- in_pc  in  ADDR_W  instruction PC
- in_data  in  DATA_W  packed operands
- in_op  in  OP_W  decoded opcode
- out_valid  out  1  head entry present
- out_ready  in  1  execute consumes head
- out_pc  out  ADDR_W  head PC
- out_data  out  DATA_W  head payload
- out_op  out  OP_W  head opcode
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
Reset (rst=0, async):
- count=0, pointers=0, storage cleared to zero, op fields to NOP_OP.
- out_valid=0, out_pc=0, out_data=0, out_op=NOP_OP, in_ready=1 (once rst released).
- Deassertion is synchronous to clk by convention upstream.

Core handshakes:
- Circular buffer; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally; count tracks full/empty (no pointer-MSB trick).
- push = rdy & in_valid & in_ready & ~flush.
- pop = rdy & out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH); registered-state only, no combinational path from out_ready.
- Latency 1: an entry pushed at edge N is visible on out_* after edge N; no same-cycle bypass.
- out_* are driven from head storage when count>0; otherwise zeros with out_op=NOP_OP.
- Simultaneous push & pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Full: in_ready=0, so no push even if pop in the same cycle (one-cycle bubble accepted by design).
- Empty: out_valid=0; pop is impossible.

Bubbles:
- in_bubble=1 with push stores op=NOP_OP; PC/data stored as given.
- out_valid=1 for bubble entries; execute treats them as no-ops.

Flush:
- flush=1 & rdy=1: at the edge count←0, rd_ptr←wr_ptr←0. Incoming instruction is dropped and any head pop is ignored.
- flush has priority over push/pop.

Global freeze:
- rdy=0: no state change, flush ignored.
- in_ready/out_valid still reflect current state; a handshake is not considered complete while rdy=0.

Reset mid-operation: immediate return to reset values regardless of rdy/flush.

Decomposition:
- Shared package/config: ADDR_W, OP_W, NOP opcode constant, payload field offsets (reg1/reg2/imm/rd) and pack/unpack helpers, True/False/ZERO_WORD.
- One natural sub-module: queue_ctrl (pointers, count, push/pop/flush arbitration, in_ready/out_valid). Storage and output mux stay in the top.

Test Plan:
- Reset: rst=0 mid-run with count=2 → out_valid=0, out_op=NOP_OP, count=0, in_ready=1 asynchronously, before the next clk edge.
- Fill/drain, DEPTH=2: push PC 0x100, 0x104 with out_ready=0 → count=2, in_ready=0; third push of 0x108 is not accepted. Set out_ready=1 → out_pc 0x100, then 0x104, then out_valid=0.
- Streaming: in_valid=out_ready=1 for 10 cycles, PCs 0x0,0x4,… → out_pc lags by exactly one cycle, count stays 1, no drops; pointer wrap exercised.
- Flush: count=2, flush=1 with in_valid=1 (PC 0x200) → next cycle count=0, out_valid=0, 0x200 absent. Next push 0x300 appears one cycle later.
- Bubble: push in_op=0x13, in_bubble=1, PC 0x40 → out_op=NOP_OP, out_pc=0x40, out_valid=1.
- Freeze: rdy=0 for 3 cycles with in_valid=out_ready=flush=1 → count, out_pc, pointers unchanged. On rdy=1 the flush takes effect.
